// File: rtl/sign_ext.sv
`default_nettype none
// ============================================================================
// Module : sign_ext
// Brief  : LEGv8 immediate generator; registered sign-extended immediate.
//          Optional formats (CBNZ, B.cond, B, BL, ADDI, SUBI) behind
//          macro SIGN_EXT_EXT_FORMATS_EN.
// Rev    : 1.0
// ============================================================================
module sign_ext (
  input  logic        clk,
  input  logic        reset,
  input  logic [31:0] a,
  output logic [63:0] y,
  output logic        fmt_hit
);

  localparam logic [10:0] C_OP_LDUR  = 11'b111_1100_0010;
  localparam logic [10:0] C_OP_STUR  = 11'b111_1100_0000;
  localparam logic [7:0]  C_OP_CBZ   = 8'b1011_0100;
`ifdef SIGN_EXT_EXT_FORMATS_EN
  localparam logic [7:0]  C_OP_CBNZ  = 8'hB5;
  localparam logic [7:0]  C_OP_BCOND = 8'h54;
  localparam logic [5:0]  C_OP_B     = 6'b000101;
  localparam logic [5:0]  C_OP_BL    = 6'b100101;
  localparam logic [9:0]  C_OP_ADDI  = 10'b1001000100;
  localparam logic [9:0]  C_OP_SUBI  = 10'b1101000100;
`endif

  logic [63:0] y_d;
  logic [63:0] y_q;
  logic        fmt_hit_d;
  logic        fmt_hit_q;

  // Register fields below the immediates never influence the result.
  logic unused_a;
  assign unused_a = ^a[4:0];

  always_comb begin
    y_d       = 64'h0;
    fmt_hit_d = 1'b0;
    if (a[31:21] == C_OP_LDUR || a[31:21] == C_OP_STUR) begin
      y_d       = {{55{a[20]}}, a[20:12]};
      fmt_hit_d = 1'b1;
    end else if (a[31:24] == C_OP_CBZ) begin
      y_d       = {{45{a[23]}}, a[23:5]};
      fmt_hit_d = 1'b1;
    end
`ifdef SIGN_EXT_EXT_FORMATS_EN
    else if (a[31:24] == C_OP_CBNZ || a[31:24] == C_OP_BCOND) begin
      y_d       = {{45{a[23]}}, a[23:5]};
      fmt_hit_d = 1'b1;
    end else if (a[31:26] == C_OP_B || a[31:26] == C_OP_BL) begin
      y_d       = {{38{a[25]}}, a[25:0]};
      fmt_hit_d = 1'b1;
    end else if (a[31:22] == C_OP_ADDI || a[31:22] == C_OP_SUBI) begin
      // Arithmetic immediates are unsigned.
      y_d       = {52'h0, a[21:10]};
      fmt_hit_d = 1'b1;
    end
`endif
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      y_q       <= 64'h0;
      fmt_hit_q <= 1'b0;
    end else begin
      y_q       <= y_d;
      fmt_hit_q <= fmt_hit_d;
    end
  end

  assign y       = y_q;
  assign fmt_hit = fmt_hit_q;

endmodule
`default_nettype wire

// File: tb/tb_sign_ext.sv
`default_nettype none
// Bench for sign_ext: stimulus at negedge, scoreboard queue checked 1 ns after posedge.
module tb_sign_ext;

  logic        clk;
  logic        reset;
  logic [31:0] a;
  logic [63:0] y;
  logic        fmt_hit;

  int n_checks = 0;
  int n_errors = 0;
  logic [64:0] exp_q[$];
  bit done = 1'b0;

  sign_ext dut (
    .clk     (clk),
    .reset   (reset),
    .a       (a),
    .y       (y),
    .fmt_hit (fmt_hit)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [64:0] got, input logic [64:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got hit=%0b y=%h, expected hit=%0b y=%h",
               tag, got[64], got[63:0], exp[64], exp[63:0]);
    end
  endtask

  typedef struct {
    string       tag;
    logic        rst_n;
    logic [31:0] word;
    logic        hit;
    logic [63:0] imm;
  } vec_t;

  vec_t vecs[$];
  string tag_q[$];

  task automatic drive(input vec_t v);
    @(negedge clk);
    reset = v.rst_n;
    a     = v.word;
    exp_q.push_back({v.hit, v.imm});
    tag_q.push_back(v.tag);
  endtask

  always @(posedge clk) begin
    #1;
    if (exp_q.size() > 0) begin
      check(tag_q.pop_front(), {fmt_hit, y}, exp_q.pop_front());
    end
  end

  initial begin
    reset = 1'b0;
    a     = 32'hF85510AD;

    for (int i = 0; i < 5; i++)
      vecs.push_back('{"reset", 1'b0, 32'hF85510AD, 1'b0, 64'h0});
    vecs.push_back('{"ldur_zero",  1'b1, 32'hF8400020, 1'b1, 64'h0});
    vecs.push_back('{"stur_zero",  1'b1, 32'hF8000020, 1'b1, 64'h0});
    vecs.push_back('{"ldur_pos",   1'b1, 32'hF84510AD, 1'b1, 64'h51});
    vecs.push_back('{"ldur_neg",   1'b1, 32'hF85510AD, 1'b1, 64'hFFFF_FFFF_FFFF_FF51});
    vecs.push_back('{"stur_neg",   1'b1, 32'hF81510AD, 1'b1, 64'hFFFF_FFFF_FFFF_FF51});
    vecs.push_back('{"ldur_rt_ign",1'b1, 32'hF8451FFF, 1'b1, 64'h51});
    vecs.push_back('{"cbz_zero",   1'b1, 32'hB4000000, 1'b1, 64'h0});
    vecs.push_back('{"cbz_pos",    1'b1, 32'hB40001E0, 1'b1, 64'hF});
    vecs.push_back('{"cbz_neg",    1'b1, 32'hB4B17420, 1'b1, 64'hFFFF_FFFF_FFFD_8BA1});
    vecs.push_back('{"cbz_rt_ign", 1'b1, 32'hB40001FF, 1'b1, 64'hF});
    vecs.push_back('{"cbz_max_neg",1'b1, 32'hB4800000, 1'b1, 64'hFFFF_FFFF_FFFC_0000});
    vecs.push_back('{"unrecog",    1'b1, 32'hAAA55AB7, 1'b0, 64'h0});
    vecs.push_back('{"mid_reset",  1'b0, 32'hF84510AD, 1'b0, 64'h0});
    vecs.push_back('{"post_reset", 1'b1, 32'hF84510AD, 1'b1, 64'h51});
`ifdef SIGN_EXT_EXT_FORMATS_EN
    vecs.push_back('{"cbnz",  1'b1, 32'hB5B17420, 1'b1, 64'hFFFF_FFFF_FFFD_8BA1});
    vecs.push_back('{"bcond", 1'b1, 32'h54FFFFE0, 1'b1, 64'hFFFF_FFFF_FFFF_FFFF});
    vecs.push_back('{"b_neg", 1'b1, 32'h17FFFFFF, 1'b1, 64'hFFFF_FFFF_FFFF_FFFF});
    vecs.push_back('{"bl_pos",1'b1, 32'h94000010, 1'b1, 64'h10});
    vecs.push_back('{"addi",  1'b1, 32'h913FFC00, 1'b1, 64'hFFF});
    vecs.push_back('{"subi",  1'b1, 32'hD1200000, 1'b1, 64'h800});
`else
    vecs.push_back('{"cbnz",  1'b1, 32'hB5B17420, 1'b0, 64'h0});
    vecs.push_back('{"bcond", 1'b1, 32'h54FFFFE0, 1'b0, 64'h0});
    vecs.push_back('{"b_neg", 1'b1, 32'h17FFFFFF, 1'b0, 64'h0});
    vecs.push_back('{"bl_pos",1'b1, 32'h94000010, 1'b0, 64'h0});
    vecs.push_back('{"addi",  1'b1, 32'h913FFC00, 1'b0, 64'h0});
    vecs.push_back('{"subi",  1'b1, 32'hD1200000, 1'b0, 64'h0});
`endif
    vecs.push_back('{"after_unrec", 1'b1, 32'hF81510AD, 1'b1, 64'hFFFF_FFFF_FFFF_FF51});

    foreach (vecs[i]) drive(vecs[i]);

    // Drain the scoreboard within a bounded number of cycles.
    for (int i = 0; i < 10 && exp_q.size() > 0; i++) @(negedge clk);
    if (exp_q.size() > 0) check("drain_timeout", 65'd0, 65'd1);
    done = 1'b1;
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

  initial begin
    #20000;
    if (!done) begin
      $display("FAIL watchdog: got timeout, expected completion");
      $fatal(1);
    end
  end

endmodule
`default_nettype wire
